// File: rtl/nes_pad_emulator.sv
// rtl/nes_pad_emulator.sv - NES controller-side 4021-style serial responder
module nes_pad_emulator #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             latch_in,
  input  logic             pulse_in,
  input  logic [7:0]       buttons,
  output logic             data_out,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] latch_sync, pulse_sync;
  logic                   latch_s, pulse_s, latch_d, pulse_d;
  logic                   latch_fall, pulse_rise;
  logic [7:0]             sr, sr_n;
  logic [3:0]             bit_cnt, bit_cnt_n;
  logic                   frame_done_n;
  logic [CNT_W-1:0]       frame_count_n;

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign pulse_s    = pulse_sync[SYNC_STAGES-1];
  assign latch_fall = latch_d & ~latch_s;
  assign pulse_rise = pulse_s & ~pulse_d;
  assign data_out   = sr[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_sync  <= '0;
      pulse_sync  <= '0;
      latch_d     <= 1'b0;
      pulse_d     <= 1'b0;
      state       <= IDLE;
      sr          <= 8'hFF;
      bit_cnt     <= 4'd0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      latch_sync  <= {latch_sync[SYNC_STAGES-2:0], latch_in};
      pulse_sync  <= {pulse_sync[SYNC_STAGES-2:0], pulse_in};
      latch_d     <= latch_s;
      pulse_d     <= pulse_s;
      state       <= state_n;
      sr          <= sr_n;
      bit_cnt     <= bit_cnt_n;
      frame_done  <= frame_done_n;
      frame_count <= frame_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    sr_n          = sr;
    bit_cnt_n     = bit_cnt;
    frame_done_n  = 1'b0;
    frame_count_n = frame_count;
    // Latch high overrides everything: parallel load, pulses ignored, mid-frame abort.
    if (latch_s) begin
      state_n   = LOAD;
      sr_n      = ~buttons;
      bit_cnt_n = 4'd0;
    end else begin
      case (state)
        LOAD: begin
          if (latch_fall) begin
            state_n   = SHIFT;
            bit_cnt_n = 4'd0;
          end
        end
        SHIFT: begin
          if (pulse_rise) begin
            sr_n      = {1'b1, sr[7:1]};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt_n == 4'd8) begin
              frame_done_n  = 1'b1;
              frame_count_n = frame_count + {{(CNT_W-1){1'b0}}, 1'b1};
              state_n       = DONE;
            end
          end
        end
        default: begin
          if (pulse_rise) sr_n = {1'b1, sr[7:1]};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_pad_emulator.sv
// tb/tb_nes_pad_emulator.sv - table-driven bench for nes_pad_emulator
module tb_nes_pad_emulator;

  typedef struct packed {
    logic [7:0]  btn;
    logic [7:0]  pulses;
    logic [11:0] bits;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        latch_in = 1'b0;
  logic        pulse_in = 1'b0;
  logic [7:0]  buttons = 8'h00;
  logic        data_out, frame_done;
  logic [15:0] frame_count;
  logic        data_out4, frame_done4;
  logic [3:0]  frame_count4;

  int vecs = 0;
  int miss = 0;
  int done_cnt = 0;
  int done_cnt4 = 0;
  logic [15:0] exp_cnt;
  vec_t tbl [5];

  always #5 clk = ~clk;

  nes_pad_emulator #(.SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .latch_in(latch_in), .pulse_in(pulse_in),
    .buttons(buttons), .data_out(data_out), .frame_done(frame_done),
    .frame_count(frame_count));

  nes_pad_emulator #(.SYNC_STAGES(2), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .latch_in(latch_in), .pulse_in(pulse_in),
    .buttons(buttons), .data_out(data_out4), .frame_done(frame_done4),
    .frame_count(frame_count4));

  always @(posedge clk) begin
    if (frame_done)  done_cnt  <= done_cnt + 1;
    if (frame_done4) done_cnt4 <= done_cnt4 + 1;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse();
    pulse_in = 1'b1; hold(8);
    pulse_in = 1'b0; hold(8);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; hold(3);
    reset_n = 1'b1; hold(3);
  endtask

  task automatic run_frame(input logic [7:0] btn, input int np, input logic [11:0] exp);
    int d0;
    d0 = done_cnt;
    buttons = btn;
    latch_in = 1'b1; hold(8);
    latch_in = 1'b0; hold(8);
    for (int k = 0; k < np; k++) begin
      chk("serial_bit", {31'd0, data_out}, {31'd0, exp[k]});
      pulse();
    end
    chk("tail_high", {31'd0, data_out}, 32'd1);
    chk("done_once", done_cnt - d0, 32'd1);
    exp_cnt = exp_cnt + 16'd1;
    chk("frame_count", {16'd0, frame_count}, {16'd0, exp_cnt});
  endtask

  initial begin
    tbl[0] = '{btn: 8'h01, pulses: 8'd8,  bits: 12'b1111_1111_1110};
    tbl[1] = '{btn: 8'h96, pulses: 8'd12, bits: 12'b1111_0110_1001};
    tbl[2] = '{btn: 8'hFF, pulses: 8'd8,  bits: 12'b1111_0000_0000};
    tbl[3] = '{btn: 8'h00, pulses: 8'd10, bits: 12'b1111_1111_1111};
    tbl[4] = '{btn: 8'h80, pulses: 8'd8,  bits: 12'b1111_0111_1111};
    exp_cnt = 16'd0;

    hold(3);
    reset_n = 1'b1; hold(3);
    chk("rst_data", {31'd0, data_out}, 32'd1);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_count", {16'd0, frame_count}, 32'd0);

    // Reset after 3 pulses of an all-pressed frame.
    buttons = 8'hFF;
    latch_in = 1'b1; hold(8);
    latch_in = 1'b0; hold(8);
    repeat (3) pulse();
    chk("mid_bit3", {31'd0, data_out}, 32'd0);
    do_reset();
    chk("mid_rst_data", {31'd0, data_out}, 32'd1);
    chk("mid_rst_done", {31'd0, frame_done}, 32'd0);
    chk("mid_rst_count", {16'd0, frame_count}, 32'd0);

    for (int i = 0; i < 5; i++)
      run_frame(tbl[i].btn, int'(tbl[i].pulses), tbl[i].bits);

    // Abort after 5 pulses, relatch with new buttons.
    begin
      int d0;
      d0 = done_cnt;
      buttons = 8'h55;
      latch_in = 1'b1; hold(8);
      latch_in = 1'b0; hold(8);
      repeat (5) pulse();
      buttons = 8'h80;
      latch_in = 1'b1; hold(8);
      chk("abort_no_done", done_cnt - d0, 32'd0);
      chk("abort_count", {16'd0, frame_count}, {16'd0, exp_cnt});
      latch_in = 1'b0; hold(8);
      for (int k = 0; k < 7; k++) begin
        chk("abort_new_bit", {31'd0, data_out}, 32'd1);
        pulse();
      end
      chk("abort_new_bit7", {31'd0, data_out}, 32'd0);
      pulse();
      exp_cnt = exp_cnt + 16'd1;
      chk("abort_done", done_cnt - d0, 32'd1);
      chk("abort_count2", {16'd0, frame_count}, {16'd0, exp_cnt});
    end

    // Pulse coincident with latch rise, plus pulses during latch high.
    begin
      int d0;
      d0 = done_cnt;
      buttons = 8'h01;
      latch_in = 1'b1; pulse_in = 1'b1; hold(8);
      pulse_in = 1'b0; hold(8);
      pulse();
      latch_in = 1'b0; hold(8);
      chk("coin_bit0", {31'd0, data_out}, 32'd0);
      pulse();
      chk("coin_bit1", {31'd0, data_out}, 32'd1);
      repeat (7) pulse();
      exp_cnt = exp_cnt + 16'd1;
      chk("coin_done", done_cnt - d0, 32'd1);
      chk("coin_count", {16'd0, frame_count}, {16'd0, exp_cnt});
    end

    // 4-bit counter wraps after 16 frames.
    do_reset();
    exp_cnt = 16'd0;
    begin
      int d4;
      d4 = done_cnt4;
      for (int f = 0; f < 17; f++) run_frame(8'h00, 8, 12'hFFF);
      chk("wrap_count4", {28'd0, frame_count4}, 32'd1);
      chk("wrap_done4", done_cnt4 - d4, 32'd17);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
